load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit for the RV32I core, directly downstream of the ALU. The ALU `result` is the effective address and `rs2` is the store data. The unit performs byte-lane steering, store strobes, load sign/zero extension and alignment checking. It drives a valid/ready data-memory port and stalls the core through `busy` until the access retires.

## Interface
Parameters: none (XLEN fixed at 32).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core requests a memory op; held high and stable until `done`
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- busy  out  1  stall core (combinational)
- done  out  1  one-cycle retire pulse
- fault  out  1  one-cycle pulse coincident with `done`: misaligned or illegal funct3
- load_data  out  32  extended load result, registered, valid when `done` and load
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  request is a write
- mem_addr  out  32  word address, `{req_addr[31:2],2'b00}`
- mem_wstrb  out  4  byte write strobes (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE**: on `req_valid`, decode and check the request.
  - Illegal funct3, any funct3[2]=1 on a store, or misalignment goes to DONE with a fault flag. No memory access occurs in that case.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise latch we, funct3, addr[1:0], addr, wdata and strobes, then go to REQ.
- **REQ**: `mem_valid`=1 and all mem_* outputs are stable from registers.
  - On `mem_ready` with a store, go to DONE.
  - On `mem_ready` with a load, go to WAIT.
- **WAIT**: on `mem_rvalid`, capture the extracted load into `load_data` and go to DONE. `mem_rvalid` is ignored in every other state.
- **DONE**: `done`=1, plus `fault` if flagged. Always returns to IDLE. `req_valid` is not sampled in DONE.
- Store steering, with off = addr[1:0]:
  - SB: wstrb = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = rs2.
- Load extraction: the byte is rdata[8*off+:8] and the half is rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `load_data` holds its value until the next successful load. A store or a fault writes 0.
- `busy` = req_valid & (state≠DONE). The core advances PC only in the `done` cycle.

## Timing
- Reset values: all outputs 0. Reset is asynchronous: assertion mid-access forces IDLE and drops `mem_valid` immediately. A late `mem_rvalid` after reset is ignored.
- Minimum store latency (ready in the first REQ cycle): req_valid at cycle 0 → mem_valid at cycle 1 → done at cycle 2.
- Minimum load latency: rvalid at cycle 2 → done at cycle 3. `mem_rvalid` is never expected in the accept cycle.
- Fault latency: done+fault at cycle 1, with no `mem_valid` ever asserted.
- Each extra `mem_ready` or `mem_rvalid` wait cycle adds exactly one cycle of latency.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE. The minimum issue interval is therefore 3 cycles for stores and 4 for loads.
- mem_* fields must not change while `mem_valid` is high and `mem_ready` is low.

## Test plan
- SB, addr 0x1003, rs2 0xAABBCCDD, ready immediate → mem_addr 0x1000, wstrb 1000, wdata 0xDDDDDDDD; done at cycle 2, fault 0.
- LB, addr 0x2001, rdata 0x12 80 34 56 (0x12803456) returned at cycle 2 → load_data 0x00000034.
  - Same access as LH at 0x2002 → 0x00001280.
  - Same access as LW at 0x2000 → 0x12803456.
  - LB at 0x2002 → 0xFFFFFF80; LBU at 0x2002 → 0x00000080.
- LW at 0x3002 → done+fault at cycle 1, mem_valid never high, load_data 0.
  - SH at 0x3001 → same fault response.
  - funct3 011 → same fault response.
- SW, mem_ready low for 3 cycles → mem_valid, addr, wstrb 1111 and wdata held stable; done one cycle after ready; busy high throughout.
- LH issued, rst_n pulled low in WAIT, then rvalid arrives after release → IDLE, no done, load_data 0, next request serviced normally.
- Random ops with random ready/rvalid delays against a reference byte-array memory model → all loads match, no strobe outside the accessed bytes.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit sitting behind the ALU.
// Decodes and checks the request, steers store bytes onto a valid/ready
// memory port, waits for read data and sign/zero-extends loads. The core is
// stalled through busy until the one-cycle done pulse.
`timescale 1ns/1ps
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        fault_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data_q;

  logic        legal;
  logic        misaligned;
  logic        req_ok;
  logic        accept;

  // Byte-enable pattern for a store of the given width at byte offset off.
  function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate the store operand across all lanes so the strobes pick the
  // right bytes regardless of offset.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] rs2);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{rs2[7:0]}};
      2'b01:   w = {2{rs2[15:0]}};
      default: w = rs2;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Request legality: funct3 must name a real access for its direction and
  // the address must be naturally aligned for the access width.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (req_we) begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010);
    end else begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
              (req_funct3 == 3'b101);
    end
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_ok = legal && !misaligned;
    accept = (state_q == S_IDLE) && req_valid;
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Faulting requests skip straight to DONE without
  // touching memory; rvalid only matters while waiting for read data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = req_ok ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture: memory fields are frozen at accept so they stay stable
  // for the whole handshake. Stores and faults clear the load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q     <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      addr_q      <= 32'd0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      if (accept) begin
        fault_q <= !req_ok;
        if (req_ok) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          off_q   <= req_addr[1:0];
          addr_q  <= {req_addr[31:2], 2'b00};
          wstrb_q <= req_we ? store_strobe(req_funct3, req_addr[1:0]) : 4'd0;
          wdata_q <= req_we ? store_lanes(req_funct3, req_wdata) : 32'd0;
        end
        if (!req_ok || req_we) begin
          load_data_q <= 32'd0;
        end
      end else if ((state_q == S_WAIT) && mem_rvalid) begin
        load_data_q <= load_extract(f3_q, off_q, mem_rdata);
      end
    end
  end

  // Outputs: memory port straight from registers; core handshake from state.
  always_comb begin
    busy      = req_valid && (state_q != S_DONE);
    done      = (state_q == S_DONE);
    fault     = (state_q == S_DONE) && fault_q;
    load_data = load_data_q;
    mem_valid = (state_q == S_REQ);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wstrb = wstrb_q;
    mem_wdata = wdata_q;
  end

endmodule
